// File: rtl/turing_arith_pkg.sv
// Arithmetic package shared by the shift-add multiplier and the restoring divider:
// common FSM state encoding and the iteration-counter width helper.
package turing_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_t;

    // Bits needed to hold an iteration count from n down to 0.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N radix-2 shift-and-add multiplier with an external N-bit adder.
// Optional MULTIPLIER_ZERO_BYPASS_EN: a zero operand finishes one cycle after acceptance.
module shift_add_multiplier
    import turing_arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_finished,
    input  logic [N-1:0]     i_multiplicand,
    input  logic [N-1:0]     i_multiplier,
    output logic [2*N-1:0]   o_product,
    output logic [N-1:0]     o_adder_augend,
    output logic [N-1:0]     o_adder_addend,
    input  logic [N-1:0]     i_adder_sum,
    input  logic             i_adder_carry
);

    localparam int CW = count_width(N);

    arith_state_t     state, state_next;
    logic [2*N-1:0]   p_q;
    logic [N-1:0]     a_q;
    logic [CW-1:0]    count_q;
    logic             accept;
    logic             bypass;

    assign accept = i_start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef MULTIPLIER_ZERO_BYPASS_EN
    assign bypass = (i_multiplicand == '0) || (i_multiplier == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = bypass ? ST_DONE : ST_RUN;
            ST_RUN:  if (count_q == CW'(1)) state_next = ST_DONE;
            ST_DONE: begin
                if (accept) state_next = bypass ? ST_DONE : ST_RUN;
                else        state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The adder result always enters the top of P, carry included, so no
    // iteration can lose a bit; a zero addend degenerates to a plain shift.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            p_q     <= '0;
            a_q     <= '0;
            count_q <= '0;
        end else if (accept) begin
            p_q     <= bypass ? '0 : {{N{1'b0}}, i_multiplier};
            a_q     <= i_multiplicand;
            count_q <= CW'(N);
        end else if (state == ST_RUN) begin
            p_q     <= {i_adder_carry, i_adder_sum, p_q[N-1:1]};
            count_q <= count_q - CW'(1);
        end
    end

    assign o_busy         = (state == ST_RUN);
    assign o_finished     = (state == ST_DONE);
    assign o_product      = p_q;
    assign o_adder_augend = p_q[2*N-1:N];
    assign o_adder_addend = p_q[0] ? a_q : '0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised self-checking bench for shift_add_multiplier (N=8) with a behavioural adder;
// expected products come from plain integer multiplication.
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             finished;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic [2*N-1:0]   product;
    logic [N-1:0]     adder_augend;
    logic [N-1:0]     adder_addend;
    logic [N-1:0]     adder_sum;
    logic             adder_carry;

    int n_compared   = 0;
    int n_mismatched = 0;

    shift_add_multiplier #(.N(N)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .o_busy         (busy),
        .o_finished     (finished),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .o_product      (product),
        .o_adder_augend (adder_augend),
        .o_adder_addend (adder_addend),
        .i_adder_sum    (adder_sum),
        .i_adder_carry  (adder_carry)
    );

    assign {adder_carry, adder_sum} = {1'b0, adder_augend} + {1'b0, adder_addend};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int expected_latency(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MULTIPLIER_ZERO_BYPASS_EN
        if (a == 0 || b == 0) return 1;
`endif
        return N + 1;
    endfunction

    // One transaction; if pulse_at > 0 a stray start with 7x7 is pulsed on that cycle.
    task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b, input int pulse_at);
        int cycles;
        int busy_cycles;
        int exp_lat;
        logic [2*N-1:0] exp_p;
        exp_p   = 16'(int'(a) * int'(b));
        exp_lat = expected_latency(a, b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        cycles      = 1;
        busy_cycles = 0;
        while (!finished && cycles < 4 * N) begin
            if (busy) busy_cycles++;
            if (cycles == pulse_at) begin
                start        = 1'b1;
                multiplicand = 7;
                multiplier   = 7;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        check_eq("finished_seen", finished, 1'b1);
        check_eq("latency", cycles, exp_lat);
        check_eq("busy_cycles", busy_cycles, exp_lat - 1);
        check_eq("product", product, exp_p);
        @(negedge clk);
        check_eq("finished_pulse", finished, 1'b0);
        check_eq("product_held", product, exp_p);
    endtask

    initial begin
        int seen;
        logic [N-1:0] ra, rb;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_finished", finished, 1'b0);
        check_eq("rst_product", product, 0);
        rst_n = 1'b1;

        run_mul(8'd13, 8'd11, 0);
        run_mul(8'd255, 8'd255, 0);
        run_mul(8'd0, 8'd77, 0);
        run_mul(8'd77, 8'd0, 0);
        run_mul(8'd3, 8'd5, 4);

        // Asynchronous abort mid-run.
        @(negedge clk);
        multiplicand = 8'd200;
        multiplier   = 8'd199;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_product", product, 0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_finished", finished, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (finished) seen++;
        end
        check_eq("abort_no_finish", seen, 0);
        run_mul(8'd21, 8'd12, 0);

        // Back-to-back with start held high.
        @(negedge clk);
        multiplicand = 8'd6;
        multiplier   = 8'd7;
        start        = 1'b1;
        seen = 0;
        while (!finished && seen < 4 * N) begin
            @(negedge clk);
            seen++;
        end
        check_eq("b2b_first_lat", seen, N + 1);
        check_eq("b2b_first", product, 42);
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        @(negedge clk);
        check_eq("b2b_pulse", finished, 1'b0);
        check_eq("b2b_busy", busy, 1'b1);
        seen = 1;
        while (!finished && seen < 4 * N) begin
            @(negedge clk);
            seen++;
        end
        check_eq("b2b_second_lat", seen, N + 1);
        check_eq("b2b_second", product, 81);
        start = 1'b0;
        @(negedge clk);
        check_eq("b2b_end_pulse", finished, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if (i % 8 == 3) ra = '0;
            if (i % 8 == 6) rb = '0;
            run_mul(ra, rb, (i % 3 == 0) ? 1 + int'($urandom_range(0, N - 2)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
